mm_stage: RTL and testbench
===========================

# mm_stage

Memory-access (MEM) stage of the five-stage RISC-V pipeline. Consumes the EX/MEM pipeline-register outputs (destination register, write enable, ALU result, memory op code, store data). It performs RV32I loads and stores over a byte-wide request/acknowledge memory port. It drives the write-back fields into the MEM/WB register and holds the upstream pipeline with a stall request while a transfer is in flight.

## Interface
- No parameters.
- clk  in  1  clock; all state changes on posedge.
- rst  in  1  reset, synchronous, active-high.
- mm_wa  in  5  destination register from EX/MEM.
- mm_we  in  1  register write enable from EX/MEM.
- mm_wn  in  32  ALU result; for memory ops this is the effective byte address.
- mm_mem_e  in  4  memory op code: 0 none, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU, 6 SB, 7 SH, 8 SW; 9–15 treated as none.
- mm_mem_n  in  32  store data (rs2 value).
- wb_wa  out  5  destination register to MEM/WB.
- wb_we  out  1  write enable to MEM/WB.
- wb_wn  out  32  write-back value to MEM/WB.
- stl  out  1  stall request to PC/IF/ID/EX/MEM pipeline registers; high means hold.
- mem_req  out  1  byte transfer request, registered.
- mem_rw  out  1  1 = write, 0 = read, registered; valid while mem_req.
- mem_addr  out  32  byte address, registered.
- mem_wdata  out  8  write byte, registered.
- mem_rdata  in  8  read byte; valid in the cycle mem_ack is high.
- mem_ack  in  1  high at a posedge while mem_req is high = current byte completed.

## Operation
- FSM states: IDLE, XFER, DONE.
- IDLE, op none: pass-through. wb_wa = mm_wa, wb_we = mm_we, wb_wn = mm_wn, stl = 0, mem_req = 0.
- IDLE, op valid (combinational):
  - stl = 1; wb_we = 0.
  - At the posedge, latch the following:
    - op, mm_wa, mm_we;
    - address = mm_wn;
    - byte count = 1/2/4 (B/H/W);
    - store data = mm_mem_n.
  - Drive mem_req = 1, mem_rw = store?1:0, mem_addr = mm_wn, mem_wdata = mm_mem_n[7:0]; go to XFER.
- XFER: stl = 1, wb_we = 0.
  - Each posedge with mem_ack = 1:
    - Byte index i (0-based, little-endian): a load stores mem_rdata into buffer bits [8i+7:8i].
    - mem_addr increments by 1, modulo 2^32; 0xFFFFFFFF wraps to 0x00000000.
    - mem_wdata becomes store byte i+1.
    - Count decrements.
  - On the ack of the last byte: mem_req <= 0, go to DONE.
  - mem_ack = 0 holds all state.
- DONE: one cycle, stl = 0; wb_wa = latched wa.
  - Loads: wb_we = latched we; wb_wn = buffer extended to 32 bits. LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend.
  - Stores: wb_we = 0, wb_wn = 0.
  - Next state is always IDLE. The stage ignores mm_mem_e in DONE, because EX/MEM still shows the finished op until this edge.
- Misaligned addresses need no special handling: transfer is byte-serial.
- A store whose latched destination register is x0 or whose we = 0 never writes back. Any load with wa = 0 still outputs wb_wa = 0; the register file discards it.

## Timing
- Reset: while rst is high, these outputs are 0: wb_wa, wb_we, wb_wn, stl, mem_req, mem_rw, mem_addr, mem_wdata. FSM goes to IDLE and the buffer and counters clear.
- Reset mid-transfer aborts. mem_req is 0 from the first posedge with rst high, and no write-back is produced.
- Non-memory op: zero added latency, combinational pass-through.
- N-byte op, ack every cycle:
  - cycle 0: IDLE, stl = 1;
  - cycles 1..N: XFER, one ack each;
  - cycle N+1: DONE, result valid, stl = 0.
  - stl is high for N+1 cycles.
- Each ack wait cycle extends XFER by one cycle.
- mem_req never drops between bytes of one op.
- mem_addr and mem_wdata change only on posedges with an ack, or on the posedge that starts an op.
- Back-to-back memory ops: a new op is accepted only from IDLE, so DONE→IDLE→XFER. There is 1 pass-through/IDLE cycle between ops.

## Test plan
- Pass-through: mem_e = 0, wa = 5, we = 1, wn = 0x1234 → same cycle wb_wa = 5, wb_we = 1, wb_wn = 0x1234, stl = 0, mem_req = 0.
- LW at 0x100, memory bytes 0x78, 0x56, 0x34, 0x12, ack always high:
  - mem_addr steps 0x100..0x103 and stl is high for 5 cycles;
  - in DONE, wb_wn = 0x12345678 and wb_we = 1.
- LB/LBU at 0x7 with byte 0xF0 → LB gives wb_wn = 0xFFFFFFF0; LBU gives 0x000000F0. LH with bytes 0x00, 0x80 → 0xFFFF8000.
- SH at 0xFFFFFFFF with data 0xAABBCCDD, ack delayed 2 cycles per byte:
  - writes 0xDD at 0xFFFFFFFF, then 0xCC at 0x00000000;
  - stl is high for 7 cycles; wb_we = 0 in DONE.
- Reset asserted during the 3rd byte of an SW → mem_req = 0 and stl = 0 after that posedge; no write-back. A following mem_e = 0 passes through.
- Back-to-back SB then LB at the same address → the read returns the byte written. Exactly one DONE per op; no duplicate transfer of the first op.

Source files
------------

// File: rtl/mm_stage.sv
// mm_stage: RV32I memory-access stage.
// Loads/stores run byte-serially over a req/ack port.
module mm_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  mm_wa,
  input  logic        mm_we,
  input  logic [31:0] mm_wn,
  input  logic [3:0]  mm_mem_e,
  input  logic [31:0] mm_mem_n,
  output logic [4:0]  wb_wa,
  output logic        wb_we,
  output logic [31:0] wb_wn,
  output logic        stl,
  output logic        mem_req,
  output logic        mem_rw,
  output logic [31:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack
);

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    DONE
  } state_t;

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LH  = 4'd2;
  localparam logic [3:0] OP_LW  = 4'd3;
  localparam logic [3:0] OP_LBU = 4'd4;
  localparam logic [3:0] OP_LHU = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;

  state_t      state_q, state_d;
  logic [3:0]  op_q, op_d;
  logic [4:0]  wa_q, wa_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [1:0]  idx_q, idx_d;
  logic [31:0] sdata_q, sdata_d;
  logic [31:0] buf_q, buf_d;
  logic        req_q, req_d;
  logic        rw_q, rw_d;
  logic [7:0]  wdata_q, wdata_d;

  logic        op_ok;
  logic        op_st;
  logic [2:0]  op_size;
  logic        ld_q;
  logic [31:0] ld_val;

  always_comb begin
    op_ok   = 1'b1;
    op_st   = 1'b0;
    op_size = 3'd1;
    case (mm_mem_e)
      OP_LB, OP_LBU: op_size = 3'd1;
      OP_LH, OP_LHU: op_size = 3'd2;
      OP_LW:         op_size = 3'd4;
      OP_SB: begin
        op_st   = 1'b1;
        op_size = 3'd1;
      end
      OP_SH: begin
        op_st   = 1'b1;
        op_size = 3'd2;
      end
      OP_SW: begin
        op_st   = 1'b1;
        op_size = 3'd4;
      end
      default: op_ok = 1'b0;
    endcase
  end

  assign ld_q = (op_q >= OP_LB) && (op_q <= OP_LHU);

  always_comb begin
    ld_val = buf_q;
    case (op_q)
      OP_LB:   ld_val = {{24{buf_q[7]}}, buf_q[7:0]};
      OP_LH:   ld_val = {{16{buf_q[15]}}, buf_q[15:0]};
      OP_LBU:  ld_val = {24'd0, buf_q[7:0]};
      OP_LHU:  ld_val = {16'd0, buf_q[15:0]};
      default: ld_val = buf_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    wa_d    = wa_q;
    we_d    = we_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sdata_d = sdata_q;
    buf_d   = buf_q;
    req_d   = req_q;
    rw_d    = rw_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (op_ok) begin
          state_d = XFER;
          op_d    = mm_mem_e;
          wa_d    = mm_wa;
          we_d    = mm_we;
          addr_d  = mm_wn;
          cnt_d   = op_size;
          idx_d   = 2'd0;
          sdata_d = mm_mem_n;
          buf_d   = 32'd0;
          req_d   = 1'b1;
          rw_d    = op_st;
          wdata_d = mm_mem_n[7:0];
        end
      end
      XFER: begin
        if (mem_ack) begin
          if (!rw_q) begin
            buf_d[{idx_q, 3'b000} +: 8] = mem_rdata;
          end
          addr_d  = addr_q + 32'd1;
          sdata_d = sdata_q >> 8;
          wdata_d = sdata_q[15:8];
          cnt_d   = cnt_q - 3'd1;
          idx_d   = idx_q + 2'd1;
          if (cnt_q == 3'd1) begin
            req_d   = 1'b0;
            state_d = DONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= 4'd0;
      wa_q    <= 5'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      cnt_q   <= 3'd0;
      idx_q   <= 2'd0;
      sdata_q <= 32'd0;
      buf_q   <= 32'd0;
      req_q   <= 1'b0;
      rw_q    <= 1'b0;
      wdata_q <= 8'd0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      wa_q    <= wa_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sdata_q <= sdata_d;
      buf_q   <= buf_d;
      req_q   <= req_d;
      rw_q    <= rw_d;
      wdata_q <= wdata_d;
    end
  end

  // Write-back fields are combinational so non-memory ops add no latency.
  always_comb begin
    wb_wa = 5'd0;
    wb_we = 1'b0;
    wb_wn = 32'd0;
    stl   = 1'b0;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          wb_wa = mm_wa;
          wb_wn = mm_wn;
          if (op_ok) begin
            stl = 1'b1;
          end else begin
            wb_we = mm_we;
          end
        end
        XFER: begin
          wb_wa = wa_q;
          stl   = 1'b1;
        end
        default: begin
          wb_wa = wa_q;
          if (ld_q) begin
            wb_we = we_q;
            wb_wn = ld_val;
          end
        end
      endcase
    end
  end

  assign mem_req   = req_q;
  assign mem_rw    = rw_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_mm_stage.sv
// tb_mm_stage: scoreboard bench for mm_stage.
// A byte memory model answers requests with a configurable ack delay.
module tb_mm_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  mm_wa;
  logic        mm_we;
  logic [31:0] mm_wn;
  logic [3:0]  mm_mem_e;
  logic [31:0] mm_mem_n;
  logic [4:0]  wb_wa;
  logic        wb_we;
  logic [31:0] wb_wn;
  logic        stl;
  logic        mem_req;
  logic        mem_rw;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_ack;

  typedef struct packed {
    logic [4:0]  wa;
    logic        we;
    logic [31:0] wn;
  } wb_t;

  wb_t         exp_q[$];
  logic [31:0] log_a[$];
  logic [7:0]  log_d[$];
  logic        log_rw[$];
  logic [7:0]  mem[bit [31:0]];
  int          ack_wait;
  int          total = 0;
  int          bad = 0;

  mm_stage dut (
    .clk       (clk),
    .rst       (rst),
    .mm_wa     (mm_wa),
    .mm_we     (mm_we),
    .mm_wn     (mm_wn),
    .mm_mem_e  (mm_mem_e),
    .mm_mem_n  (mm_mem_n),
    .wb_wa     (wb_wa),
    .wb_we     (wb_we),
    .wb_wn     (wb_wn),
    .stl       (stl),
    .mem_req   (mem_req),
    .mem_rw    (mem_rw),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // Memory responder: decides ack for the coming posedge.
  initial begin
    int w;
    w = 0;
    mem_ack = 1'b0;
    mem_rdata = 8'h00;
    forever begin
      @(negedge clk);
      if (mem_req && !rst) begin
        if (w >= ack_wait) begin
          w = 0;
          mem_ack = 1'b1;
          log_a.push_back(mem_addr);
          log_rw.push_back(mem_rw);
          if (mem_rw) begin
            mem[mem_addr] = mem_wdata;
            log_d.push_back(mem_wdata);
          end else begin
            mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : 8'h00;
            log_d.push_back(mem_rdata);
          end
        end else begin
          w++;
          mem_ack = 1'b0;
        end
      end else begin
        w = 0;
        mem_ack = 1'b0;
      end
    end
  end

  task automatic run_op(input string tag,
                        input logic [3:0] e,
                        input logic [4:0] wa,
                        input logic we,
                        input logic [31:0] wn,
                        input logic [31:0] mn,
                        input int wt,
                        input int n_stl,
                        input wb_t exp);
    int stl_n;
    bit done;
    wb_t w;
    stl_n = 0;
    done = 1'b0;
    log_a.delete();
    log_d.delete();
    log_rw.delete();
    ack_wait = wt;
    mm_mem_e = e;
    mm_wa = wa;
    mm_we = we;
    mm_wn = wn;
    mm_mem_n = mn;
    exp_q.push_back(exp);
    for (int c = 0; c < 60 && !done; c++) begin
      @(negedge clk);
      if (stl) begin
        if (stl_n > 0) check({tag, " req held"}, mem_req, 1);
        stl_n++;
      end else begin
        w = exp_q.pop_front();
        check({tag, " wb_wa"}, wb_wa, w.wa);
        check({tag, " wb_we"}, wb_we, w.we);
        check({tag, " wb_wn"}, wb_wn, w.wn);
        check({tag, " stl cycles"}, stl_n, n_stl);
        check({tag, " req low"}, mem_req, 0);
        done = 1'b1;
      end
    end
    check({tag, " completed"}, done, 1);
    @(posedge clk);
    #1;
    mm_mem_e = 4'd0;
  endtask

  initial begin
    #500000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    ack_wait = 0;
    mm_mem_e = 4'd3;
    mm_wa = 5'd5;
    mm_we = 1'b1;
    mm_wn = 32'h1234;
    mm_mem_n = 32'h0;
    mem[32'h100] = 8'h78;
    mem[32'h101] = 8'h56;
    mem[32'h102] = 8'h34;
    mem[32'h103] = 8'h12;
    mem[32'h7]   = 8'hF0;
    mem[32'h10]  = 8'h00;
    mem[32'h11]  = 8'h80;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst wb_wa", wb_wa, 0);
    check("rst wb_we", wb_we, 0);
    check("rst wb_wn", wb_wn, 0);
    check("rst stl", stl, 0);
    check("rst req", mem_req, 0);
    check("rst rw", mem_rw, 0);
    check("rst addr", mem_addr, 0);
    check("rst wdata", mem_wdata, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    mm_mem_e = 4'd0;

    run_op("pass", 4'd0, 5'd5, 1'b1, 32'h1234, 32'h0, 0, 0,
           '{wa: 5'd5, we: 1'b1, wn: 32'h1234});
    run_op("lw", 4'd3, 5'd7, 1'b1, 32'h100, 32'h0, 0, 5,
           '{wa: 5'd7, we: 1'b1, wn: 32'h12345678});
    check("lw bytes", log_a.size(), 4);
    for (int i = 0; i < 4 && i < log_a.size(); i++) begin
      check("lw addr", log_a[i], 32'h100 + i);
      check("lw rw", log_rw[i], 0);
    end
    run_op("lb", 4'd1, 5'd8, 1'b1, 32'h7, 32'h0, 0, 2,
           '{wa: 5'd8, we: 1'b1, wn: 32'hFFFFFFF0});
    run_op("lbu", 4'd4, 5'd8, 1'b1, 32'h7, 32'h0, 1, 3,
           '{wa: 5'd8, we: 1'b1, wn: 32'h000000F0});
    run_op("lh", 4'd2, 5'd9, 1'b1, 32'h10, 32'h0, 0, 3,
           '{wa: 5'd9, we: 1'b1, wn: 32'hFFFF8000});
    run_op("lhu", 4'd5, 5'd0, 1'b1, 32'h10, 32'h0, 0, 3,
           '{wa: 5'd0, we: 1'b1, wn: 32'h00008000});
    run_op("sh", 4'd7, 5'd3, 1'b1, 32'hFFFFFFFF, 32'hAABBCCDD, 2, 7,
           '{wa: 5'd3, we: 1'b0, wn: 32'h0});
    check("sh bytes", log_a.size(), 2);
    if (log_a.size() == 2) begin
      check("sh a0", log_a[0], 32'hFFFFFFFF);
      check("sh d0", log_d[0], 32'hDD);
      check("sh a1", log_a[1], 32'h0);
      check("sh d1", log_d[1], 32'hCC);
      check("sh rw", log_rw[1], 1);
    end
    run_op("inv", 4'd9, 5'd9, 1'b1, 32'hABCD, 32'h0, 0, 0,
           '{wa: 5'd9, we: 1'b1, wn: 32'hABCD});
    run_op("sb", 4'd6, 5'd4, 1'b1, 32'h40, 32'h123456A5, 0, 2,
           '{wa: 5'd4, we: 1'b0, wn: 32'h0});
    check("sb bytes", log_a.size(), 1);
    run_op("lb2", 4'd1, 5'd6, 1'b1, 32'h40, 32'h0, 0, 2,
           '{wa: 5'd6, we: 1'b1, wn: 32'hFFFFFFA5});
    check("lb2 bytes", log_a.size(), 1);

    log_a.delete();
    log_d.delete();
    log_rw.delete();
    ack_wait = 0;
    mm_mem_e = 4'd8;
    mm_wa = 5'd2;
    mm_we = 1'b1;
    mm_wn = 32'h200;
    mm_mem_n = 32'h11223344;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("abort stl", stl, 0);
    check("abort wb_we", wb_we, 0);
    @(posedge clk);
    #1;
    check("abort req", mem_req, 0);
    check("abort stl2", stl, 0);
    rst = 1'b0;
    mm_mem_e = 4'd0;
    mm_wa = 5'd5;
    mm_wn = 32'h55;
    @(negedge clk);
    check("post wb_wn", wb_wn, 32'h55);
    check("post wb_we", wb_we, 1);
    check("post stl", stl, 0);
    check("post req", mem_req, 0);
    check("abort bytes", log_a.size(), 2);
    check("sb left", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
